// File: rtl/vga_scan_compositor.sv
// VGA raster generator and priority compositor for NUM_OBJ drawer inputs.
// Optional macro VGA_COLLISION_EN adds a registered multi-object overlap flag.
module vga_scan_compositor #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          NUM_OBJ  = 4,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    output logic [10:0]            oCoord_X,
    output logic [10:0]            oCoord_Y,
    input  logic [NUM_OBJ-1:0]     obj_draw_req,
    input  logic [8*NUM_OBJ-1:0]   obj_RGB,
    output logic [7:0]             mVGA_RGB,
    output logic                   hsync_n,
    output logic                   vsync_n,
    output logic                   blank_n,
    output logic                   start_of_frame
`ifdef VGA_COLLISION_EN
    ,
    output logic                   collision
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2047 || V_TOTAL > 2047 || NUM_OBJ < 1 || NUM_OBJ > 16) begin : g_param_check
            $error("vga_scan_compositor: timing totals must fit 11 bits and NUM_OBJ must be 1..16");
        end
    endgenerate

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
    localparam logic [10:0] H_HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        active_p0, hs_p0, vs_p0;
    logic        active_p1_q, active_p1_d;
    logic        hs_p1_q, hs_p1_d;
    logic        vs_p1_q, vs_p1_d;
    logic        active_p2_q, active_p2_d;
    logic        hs_p2_q, hs_p2_d;
    logic        vs_p2_q, vs_p2_d;
    logic [7:0]  rgb_p2_q, rgb_p2_d;
    logic [7:0]  win_rgb;

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
        end
    end

    // Stage 0: timing decode straight off the counters
    always_comb begin
        active_p0 = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hs_p0     = (h_cnt_q >= H_HS_BEG) && (h_cnt_q < H_HS_END);
        vs_p0     = (v_cnt_q >= V_VS_BEG) && (v_cnt_q < V_VS_END);
        active_p1_d = active_p0;
        hs_p1_d     = hs_p0;
        vs_p1_d     = vs_p0;
    end

    // Stage 1: drawer requests arrive here, aligned to the stage-1 coordinate
    always_comb begin
        win_rgb = BG_COLOR;
        // Walk from the highest index down so the lowest requesting index wins.
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (obj_draw_req[i]) begin
                win_rgb = obj_RGB[8*i +: 8];
            end
        end
        rgb_p2_d    = active_p1_q ? win_rgb : 8'h00;
        active_p2_d = active_p1_q;
        hs_p2_d     = hs_p1_q;
        vs_p2_d     = vs_p1_q;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            active_p1_q <= 1'b0;
            hs_p1_q     <= 1'b0;
            vs_p1_q     <= 1'b0;
            active_p2_q <= 1'b0;
            hs_p2_q     <= 1'b0;
            vs_p2_q     <= 1'b0;
            rgb_p2_q    <= 8'h00;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            active_p1_q <= active_p1_d;
            hs_p1_q     <= hs_p1_d;
            vs_p1_q     <= vs_p1_d;
            active_p2_q <= active_p2_d;
            hs_p2_q     <= hs_p2_d;
            vs_p2_q     <= vs_p2_d;
            rgb_p2_q    <= rgb_p2_d;
        end
    end

`ifdef VGA_COLLISION_EN
    logic coll_p2_q, coll_p2_d;
    logic seen_req, multi_req;

    always_comb begin
        seen_req  = 1'b0;
        multi_req = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (obj_draw_req[i]) begin
                if (seen_req) begin
                    multi_req = 1'b1;
                end
                seen_req = 1'b1;
            end
        end
        coll_p2_d = active_p1_q && multi_req;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            coll_p2_q <= 1'b0;
        end else begin
            coll_p2_q <= coll_p2_d;
        end
    end

    assign collision = coll_p2_q;
`endif

    // Stage 2: registered outputs to the DAC, two clocks behind oCoord
    assign oCoord_X       = h_cnt_q;
    assign oCoord_Y       = v_cnt_q;
    assign mVGA_RGB       = rgb_p2_q;
    assign hsync_n        = ~hs_p2_q;
    assign vsync_n        = ~vs_p2_q;
    assign blank_n        = active_p2_q;
    // Counters sit at (0,0) during reset, so the pulse is gated by RESETn.
    assign start_of_frame = RESETn && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

endmodule
